// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed common-anode 7-segment scanner with blink, dp and dead time.
// Optional leading-zero suppression is built when SEG_SCAN_LZ_BLANK_EN is defined.
`default_nettype none

module seg_scan_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 2,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    blink_phase
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [DW-1:0] c_DIV_LAST   = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] c_IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] c_BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [DW-1:0]         r_div_cnt;
    logic [IW-1:0]         r_idx;
    logic [BW-1:0]         r_blink_cnt;
    logic                  r_blink_phase;
    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]            r_seg;

    logic                  w_dead;
    logic                  w_blank;
    logic                  w_lz_blank;
    logic [3:0]            w_nibble;
    logic [6:0]            w_glyph;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS-1:0] w_an_next;
    logic [7:0]            w_seg_next;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] v;
        case (nib)
            4'h0: v = 7'h40;
            4'h1: v = 7'h79;
            4'h2: v = 7'h24;
            4'h3: v = 7'h30;
            4'h4: v = 7'h19;
            4'h5: v = 7'h12;
            4'h6: v = 7'h02;
            4'h7: v = 7'h78;
            4'h8: v = 7'h00;
            4'h9: v = 7'h10;
            4'hA: v = 7'h08;
            4'hB: v = 7'h03;
            4'hC: v = 7'h46;
            4'hD: v = 7'h21;
            4'hE: v = 7'h06;
            default: v = 7'h0E;
        endcase
        return v;
    endfunction

    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign w_dead = 1'b0;
        end else begin : g_dead
            localparam logic [DW-1:0] c_DEAD = DW'(DEAD_CYCLES);
            assign w_dead = (r_div_cnt < c_DEAD);
        end
    endgenerate

`ifdef SEG_SCAN_LZ_BLANK_EN
    // w_lz_sup[i]: every nibble from the top down to i is zero with no dp set.
    logic [NUM_DIGITS-1:0] w_lz_sup;
    assign w_lz_sup[0] = 1'b0;
    generate
        for (genvar gi = NUM_DIGITS - 1; gi >= 1; gi--) begin : g_lz
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign w_lz_sup[gi] = (digits[4*gi +: 4] == 4'h0) & ~dp_mask[gi];
            end else begin : g_chain
                assign w_lz_sup[gi] = w_lz_sup[gi+1] & (digits[4*gi +: 4] == 4'h0) & ~dp_mask[gi];
            end
        end
    endgenerate
    assign w_lz_blank = w_lz_sup[r_idx];
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_nibble   = digits[4*int'(r_idx) +: 4];
    assign w_glyph    = f_decode(w_nibble);
    assign w_onehot   = NUM_DIGITS'(1) << r_idx;
    assign w_blank    = ~en | w_dead;
    assign w_an_next  = w_blank ? '1 : ~w_onehot;
    assign w_seg_next = (w_blank | (r_blink_phase & blink_mask[r_idx]) | w_lz_blank)
                        ? 8'hFF : {~dp_mask[r_idx], w_glyph};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_idx         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_an          <= '1;
            r_seg         <= 8'hFF;
        end else begin
            if (r_div_cnt == c_DIV_LAST) begin
                r_div_cnt <= '0;
                r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign blink_phase = r_blink_phase;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: vector table plus randomized run against a time-indexed reference model.
`default_nettype none

module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int DC = 1;
    localparam int BD = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b1;
    logic [15:0]   digits = 16'h0;
    logic [3:0]    blink_mask = 4'h0;
    logic [3:0]    dp_mask = 4'h0;
    logic [3:0]    an;
    logic [7:0]    seg;
    logic          blink_phase;

    int errors = 0;
    int checks = 0;
    int k = 0;

    logic [7:0] c_dec [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] dig;
        logic [3:0]  bm;
        logic [3:0]  dm;
        logic [3:0]  an;
        logic [7:0]  seg;
        logic        bp;
    } vec_t;

    vec_t tbl[19];

    seg_scan_display #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC),
        .BLINK_DIV  (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits     (digits),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    // Clock one edge, compare outputs, and advance the time-since-reset count.
    task automatic check(input logic [3:0] e_an, input logic [7:0] e_seg,
                         input logic e_bp, input string tag);
        @(posedge clk);
        #1;
        checks++;
        if (an !== e_an || seg !== e_seg || blink_phase !== e_bp) begin
            errors++;
            $display("FAIL %s k=%0d: an=%h seg=%h bp=%b, expected an=%h seg=%h bp=%b",
                     tag, k, an, seg, blink_phase, e_an, e_seg, e_bp);
        end
        if (rst) k = 0;
        else     k++;
    endtask

    function automatic bit lz_sup(input int id);
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (id == 0) return 1'b0;
        for (int j = id; j < ND; j++)
            if (digits[4*j +: 4] != 4'h0 || dp_mask[j]) return 1'b0;
        return 1'b1;
`else
        return (id < 0);
`endif
    endfunction

    // Expected outputs derived from k, the number of non-reset edges since reset.
    task automatic model_tick(input string tag);
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic       e_bp;
        logic [3:0] nib;
        int div, id, ph;
        if (rst) begin
            e_an = 4'hF; e_seg = 8'hFF; e_bp = 1'b0;
        end else begin
            div  = k % RD;
            id   = (k / RD) % ND;
            ph   = (k / BD) % 2;
            e_bp = (((k + 1) / BD) % 2) == 1;
            if (!en || div < DC) begin
                e_an = 4'hF; e_seg = 8'hFF;
            end else begin
                e_an = ~(4'b0001 << id);
                nib  = digits[4*id +: 4];
                if ((ph == 1 && blink_mask[id]) || lz_sup(id))
                    e_seg = 8'hFF;
                else
                    e_seg = {~dp_mask[id], c_dec[nib][6:0]};
            end
        end
        check(e_an, e_seg, e_bp, tag);
    endtask

    initial begin
        tbl[0]  = '{1, 1, 16'h1234, 4'h0, 4'h0, 4'hF, 8'hFF, 0};
        tbl[1]  = '{1, 1, 16'h1234, 4'h0, 4'h0, 4'hF, 8'hFF, 0};
        tbl[2]  = '{1, 1, 16'h1234, 4'h0, 4'h0, 4'hF, 8'hFF, 0};
        tbl[3]  = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hF, 8'hFF, 0};
        tbl[4]  = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hE, 8'h99, 0};
        tbl[5]  = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hE, 8'h99, 0};
        tbl[6]  = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hE, 8'h99, 0};
        tbl[7]  = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hF, 8'hFF, 0};
        tbl[8]  = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hD, 8'hB0, 0};
        tbl[9]  = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hD, 8'hB0, 0};
        tbl[10] = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hD, 8'hB0, 0};
        tbl[11] = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hF, 8'hFF, 0};
        tbl[12] = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hB, 8'hA4, 0};
        tbl[13] = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hB, 8'hA4, 0};
        tbl[14] = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hB, 8'hA4, 0};
        tbl[15] = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'hF, 8'hFF, 0};
        tbl[16] = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'h7, 8'hF9, 0};
        tbl[17] = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'h7, 8'hF9, 0};
        tbl[18] = '{0, 1, 16'h1234, 4'h0, 4'h0, 4'h7, 8'hF9, 1};

        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; digits = tbl[i].dig;
            blink_mask = tbl[i].bm; dp_mask = tbl[i].dm;
            check(tbl[i].an, tbl[i].seg, tbl[i].bp, $sformatf("table[%0d]", i));
        end

        for (int i = 0; i < 16; i++) model_tick("scan_wrap");

        digits = 16'hFEDA; dp_mask = 4'b0010;
        for (int i = 0; i < 16; i++) model_tick("hex_dp");

        dp_mask = 4'h0; digits = 16'h1234; blink_mask = 4'b0100;
        for (int i = 0; i < 64; i++) model_tick("blink");
        blink_mask = 4'h0;

        for (int i = 0; i < RD && (k % RD) != 2; i++) model_tick("pre_en");
        en = 1'b0;
        for (int i = 0; i < 7; i++) model_tick("en_off");
        en = 1'b1;
        for (int i = 0; i < 12; i++) model_tick("en_resume");

        for (int i = 0; i < ND*RD && !(((k / RD) % ND) == 2 && (k % RD) == 2); i++)
            model_tick("pre_rst");
        rst = 1'b1;
        check(4'hF, 8'hFF, 1'b0, "mid_rst");
        rst = 1'b0;
        check(4'hF, 8'hFF, 1'b0, "rst_dark");
        check(4'hE, 8'h99, 1'b0, "rst_digit0");
        for (int i = 0; i < 14; i++) model_tick("post_rst");

        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            en         = ($urandom_range(0, 7) != 0);
            digits     = 16'($urandom);
            blink_mask = 4'($urandom);
            dp_mask    = 4'($urandom);
            model_tick("random");
        end

        rst = 1'b0; en = 1'b1; blink_mask = 4'h0;
        digits = 16'h0050; dp_mask = 4'h0;
        for (int i = 0; i < 16; i++) model_tick("lz_0050");
        dp_mask = 4'b0100;
        for (int i = 0; i < 16; i++) model_tick("lz_dp");
        digits = 16'h0000; dp_mask = 4'h0;
        for (int i = 0; i < 16; i++) model_tick("lz_zero");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
